// File: rtl/serial_adder.sv
// ============================================================================
// Module   : serial_adder
// Brief    : Multi-cycle add/subtract, CHUNK bits per clock, valid/ready on
//            both sides. Optional saturation via `define SERIAL_ADDER_SAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int c_num_slices = WIDTH / CHUNK;
  localparam int c_kw         = (c_num_slices > 1) ? $clog2(c_num_slices) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [c_kw-1:0]  r_k;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  int               w_base;
  logic [CHUNK-1:0] w_a_slice;
  logic [CHUNK-1:0] w_b_slice;
  logic [CHUNK:0]   w_slice;
  logic             w_last;
  logic             w_msb_cin;
  logic             w_ovf;

  assign w_base    = int'(r_k) * CHUNK;
  assign w_a_slice = r_a[w_base +: CHUNK];
  assign w_b_slice = r_b[w_base +: CHUNK];
  assign w_slice   = {1'b0, w_a_slice} + {1'b0, w_b_slice} + {{CHUNK{1'b0}}, r_carry};
  assign w_last    = (r_k == c_kw'(c_num_slices - 1));
  // Carry into the top bit recovered from its sum bit: s = a ^ b ^ c.
  assign w_msb_cin = w_a_slice[CHUNK-1] ^ w_b_slice[CHUNK-1] ^ w_slice[CHUNK-1];
  assign w_ovf     = w_msb_cin ^ w_slice[CHUNK];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_next = RUN;
      RUN:     if (w_last)    w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_k     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= cin ^ sub;
            r_k     <= '0;
          end
        end
        RUN: begin
          r_sum[w_base +: CHUNK] <= w_slice[CHUNK-1:0];
          r_carry                <= w_slice[CHUNK];
          r_k                    <= r_k + 1'b1;
          if (w_last) begin
            r_cout <= w_slice[CHUNK];
            r_ovf  <= w_ovf;
`ifdef SERIAL_ADDER_SAT_EN
            // On overflow both operands share A's sign, so A's MSB picks the rail.
            if (w_ovf) begin
              r_sum <= r_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                    : {1'b0, {(WIDTH-1){1'b1}}};
            end
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign overflow  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
// Module   : tb_serial_adder
// Brief    : Scoreboard bench for serial_adder (WIDTH=16, CHUNK=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_adder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] sum;
  logic        cout;
  logic        overflow;

  logic [17:0] q[$];
  int          checks = 0;
  int          passes = 0;
  int          pushed = 0;
  int          popped = 0;

  serial_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference: exact integer arithmetic, result {cout, overflow, sum}.
  function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic mc, input logic ms);
    int ua, ub, sa, sb, ci, u, s;
    logic co, ov;
    logic [15:0] r;
    ua = int'(ma);
    ub = int'(mb);
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    ci = mc ? 1 : 0;
    if (!ms) begin
      u  = ua + ub + ci;
      s  = sa + sb + ci;
      co = (u > 65535);
    end else begin
      u  = ua - ub - ci;
      s  = sa - sb - ci;
      co = (ua >= ub + ci);
    end
    ov = (s > 32767) || (s < -32768);
    r  = u[15:0];
`ifdef SERIAL_ADDER_SAT_EN
    if (ov) r = (s > 0) ? 16'h7FFF : 16'h8000;
`endif
    return {co, ov, r};
  endfunction

  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        $display("FAIL spurious_output: got sum %h with nothing expected", sum);
      end else begin
        logic [17:0] e;
        e = q.pop_front();
        popped++;
        chk("sum", 32'(sum), 32'(e[15:0]));
        chk("cout", 32'(cout), 32'(e[17]));
        chk("overflow", 32'(overflow), 32'(e[16]));
      end
    end
  end

  // Called at #1 after a rising edge; returns at #1 after the consume edge.
  task automatic issue(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                       input logic ts, input int stall);
    logic [17:0] e;
    int waited;
    int lat;
    int busy;
    waited = 0;
    while (in_ready !== 1'b1 && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    out_ready = (stall == 0);
    in_valid  = 1'b1;
    a = ta; b = tb_; cin = tc; sub = ts;
    e = model(ta, tb_, tc, ts);
    q.push_back(e);
    pushed++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom);
    cin = 1'($urandom); sub = 1'($urandom);
    lat = 0;
    busy = 0;
    while (out_valid !== 1'b1 && lat < 10) begin
      if (in_ready !== 1'b0) busy++;
      @(posedge clk); #1;
      lat++;
    end
    if (in_ready !== 1'b0) busy++;
    chk("latency", 32'(lat), 32'd4);
    chk("in_ready_busy", 32'(busy), 32'd0);
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'($urandom);
      a = 16'($urandom); b = 16'($urandom);
      @(posedge clk); #1;
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_ready", 32'(in_ready), 32'd0);
      chk("hold_result", 32'({cout, overflow, sum}), 32'(e));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_consume", 32'(in_ready), 32'd1);
    chk("valid_after_consume", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'({cout, overflow, sum}), 32'd0);
    reset = 1'b0;

    issue(16'h1234, 16'h0FFF, 1'b0, 1'b0, 0);
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
    issue(16'hFFFF, 16'h0000, 1'b1, 1'b0, 0);
    issue(16'h0005, 16'h0007, 1'b0, 1'b1, 0);
    issue(16'h8000, 16'h0001, 1'b0, 1'b1, 0);
    issue(16'h8000, 16'hFFFF, 1'b0, 1'b0, 0);
    issue(16'h0000, 16'h0000, 1'b1, 1'b1, 0);
    issue(16'h4321, 16'h1111, 1'b0, 1'b0, 5);

    // Reset during the second RUN cycle discards the operation.
    in_valid = 1'b1;
    a = 16'hAAAA; b = 16'h5555; cin = 1'b1; sub = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrun_rst_in_ready", 32'(in_ready), 32'd1);
    chk("midrun_rst_out_valid", 32'(out_valid), 32'd0);
    chk("midrun_rst_result", 32'({cout, overflow, sum}), 32'd0);
    reset = 1'b0;
    issue(16'h00FF, 16'h0001, 1'b0, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      issue(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
            int'($urandom_range(0, 2)));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    chk("output_count", 32'(popped), 32'(pushed));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_adder.md
# serial_adder

Multi-cycle, parametrised add/subtract unit that processes WIDTH-bit operands CHUNK bits per clock, using a CHUNK-bit carry chain registered between slices. It provides a valid/ready handshake on both sides, borrow-style subtraction, carry-out and signed-overflow flags, and an optional saturation mode. It is the sequential successor to the combinational ripple adder. Game logic uses it for score/line counters and wide coordinate arithmetic where a single-cycle WIDTH-bit chain does not close timing.

## Interface
- WIDTH, 16: operand/result width in bits; must be ≥2.
- CHUNK, 4: bits added per cycle; must divide WIDTH. N = WIDTH/CHUNK slices.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operands present.
- in_ready  output  1  unit can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in for add, borrow-in for subtract.
- sub  input  1  0 selects a+b+cin; 1 selects a−b−cin.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of bit WIDTH−1. For subtract, 1 means no borrow.
- overflow  output  1  two's-complement signed overflow.

## Operation
- States: IDLE, RUN, DONE. Reset lands in IDLE.
- IDLE
  - in_ready=1.
  - On in_valid: latch a, latch b (or ~b if sub), and carry = cin (or ~cin if sub).
  - Clear the slice counter k and go to RUN.
- RUN
  - in_ready=0.
  - Each cycle, add slice k of A, slice k of B' and carry.
  - Write the CHUNK-bit result into sum[k*CHUNK +: CHUNK] and register the slice carry-out as the next carry.
  - k increments. On k=N−1, go to DONE instead.
- Last slice
  - Capture c_msb_in (carry into bit WIDTH−1) and c_out (carry out of bit WIDTH−1).
  - cout=c_out; overflow=c_msb_in^c_out.
- DONE
  - out_valid=1.
  - sum, cout and overflow are held stable until out_valid&out_ready. Then go to IDLE.
  - in_valid is ignored outside IDLE.
- Arithmetic is modulo 2^WIDTH. Subtraction is a + ~b + ~cin, i.e. a−b−cin.
- CHUNK=WIDTH is legal: N=1, one RUN cycle.
- Reset in any state has priority:
  - Next cycle is IDLE; sum, cout, overflow, out_valid and k are all 0; in_ready=1.
  - Any in-flight operation is discarded.

## Timing
- Reset values: in_ready=1, out_valid=0, sum=0, cout=0, overflow=0.
- Accept edge t (IDLE, in_valid=1): RUN during cycles t+1..t+N, and out_valid rises after edge t+N.
- Result consumed at the first edge with out_valid&out_ready. in_ready rises in the following cycle.
- Minimum initiation interval: N+2 cycles, with in_valid and out_ready held high.
- in_ready is a registered state decode, not combinationally dependent on out_ready.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- SERIAL_ADDER_SAT_EN defined:
  - On the last slice, if overflow, sum is replaced by signed saturation: 0 followed by WIDTH−1 ones when the true result is positive (A MSB = 0), else 1 followed by WIDTH−1 zeros.
  - overflow and cout still report the unsaturated flags.
  - Latency is unchanged.
- Not defined: sum is the wrapped result. No saturation logic is built.

## Test plan
All scenarios use WIDTH=16, CHUNK=4 (N=4).

1. Reset, then a=0x1234, b=0x0FFF, cin=0, sub=0, out_ready=1.
   - Required: sum=0x2233, cout=0, overflow=0.
   - out_valid rises exactly 4 edges after accept; in_ready=0 throughout RUN and DONE.
2. a=0x7FFF, b=0x0001, add.
   - Required: sum=0x8000, overflow=1, cout=0.
   - With SERIAL_ADDER_SAT_EN: sum=0x7FFF, overflow=1.
3. a=0xFFFF, b=0x0000, cin=1, add → sum=0x0000, cout=1, overflow=0.
   - Then a=0x0005, b=0x0007, cin=0, sub=1 → sum=0xFFFE, cout=0, overflow=0.
4. a=0x8000, b=0x0001, sub=1.
   - Required: sum=0x7FFF, cout=1, overflow=1.
   - With SERIAL_ADDER_SAT_EN: sum=0x8000.
5. Complete an add, then hold out_ready=0 for 5 cycles while toggling in_valid, a and b.
   - out_valid stays 1; sum, cout and overflow stay stable; in_ready stays 0; no new accept.
   - After out_ready=1: one cycle later, in_ready=1.
6. Assert reset in the 2nd RUN cycle.
   - Next cycle: IDLE, in_ready=1, out_valid=0, sum=0.
   - A following op a=0x00FF, b=0x0001 yields 0x0100 with normal latency.
